// File: rtl/write_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : write_buf_pkg
// Purpose  : Shared constants and types for the conv buffer write controller.
//            The bank/width defaults track the CNN_defines.vh macros used by
//            the conv read path, so both sides agree on the bank layout.
// Contents : *_DEF parameter defaults, wbuf_state_e FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package write_buf_pkg;

   localparam int BRAM_NUM_DEF        = 16;
   localparam int LOG2_BRAM_NUM_DEF   = 4;
   localparam int LOG2_BRAM_DEPTH_DEF = 10;
   localparam int BASE_TIN_DEF        = 8;
   localparam int MAX_DW_DEF          = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } wbuf_state_e;

endpackage : write_buf_pkg
`default_nettype wire

// File: rtl/write_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : write_buf_if
// Purpose  : Command, DMA data stream and logic-memory write-port bundle of
//            write_buf.
// Modports : master - command/data source (loader side)
//            slave  - write_buf itself
// Revision : 1.0 - initial release
// ============================================================================
interface write_buf_if
   import write_buf_pkg::*;
#(
   parameter int BRAM_NUM        = BRAM_NUM_DEF,
   parameter int LOG2_BRAM_NUM   = LOG2_BRAM_NUM_DEF,
   parameter int LOG2_BRAM_DEPTH = LOG2_BRAM_DEPTH_DEF,
   parameter int BASE_TIN        = BASE_TIN_DEF,
   parameter int MAX_DW          = MAX_DW_DEF
) ();
   localparam int LOG2BUF_DEP = LOG2_BRAM_NUM + LOG2_BRAM_DEPTH;
   localparam int BEAT_W      = BASE_TIN * MAX_DW;

   logic [LOG2_BRAM_NUM-1:0]            dat_buf_num;
   logic                                cmd_vld;
   logic                                cmd_rdy;
   logic                                cmd_is_wt;
   logic [LOG2BUF_DEP-1:0]              cmd_addr;
   logic [LOG2BUF_DEP:0]                cmd_len;
   logic                                in_vld;
   logic                                in_rdy;
   logic [BEAT_W-1:0]                   in_dat;
   logic [BRAM_NUM-1:0]                 logic_mem_wr_en;
   logic [BRAM_NUM*LOG2_BRAM_DEPTH-1:0] logic_mem_wr_addr;
   logic [BEAT_W-1:0]                   logic_mem_wr_dat;
   logic                                done;
   logic                                err;

   modport master (
      output dat_buf_num, cmd_vld, cmd_is_wt, cmd_addr, cmd_len, in_vld, in_dat,
      input  cmd_rdy, in_rdy, logic_mem_wr_en, logic_mem_wr_addr,
             logic_mem_wr_dat, done, err
   );

   modport slave (
      input  dat_buf_num, cmd_vld, cmd_is_wt, cmd_addr, cmd_len, in_vld, in_dat,
      output cmd_rdy, in_rdy, logic_mem_wr_en, logic_mem_wr_addr,
             logic_mem_wr_dat, done, err
   );

endinterface : write_buf_if
`default_nettype wire

// File: rtl/write_buf_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : wbuf_addr_gen
// Purpose  : Address generator for write_buf. Latches region base/limit and
//            start offset on load, counts accepted beats and produces the
//            bank index / in-bank address of the current beat plus an
//            in-region flag.
// Ports    : load/is_wt/dat_buf_num/start_addr - command capture
//            step                               - beat accepted this cycle
//            cnt                                - beats accepted so far
//            bank/bank_addr/in_bound            - target of the current beat
// Revision : 1.0 - initial release
// ============================================================================
module wbuf_addr_gen
   import write_buf_pkg::*;
#(
   parameter int BRAM_NUM        = BRAM_NUM_DEF,
   parameter int LOG2_BRAM_NUM   = LOG2_BRAM_NUM_DEF,
   parameter int LOG2_BRAM_DEPTH = LOG2_BRAM_DEPTH_DEF,
   localparam int LOG2BUF_DEP    = LOG2_BRAM_NUM + LOG2_BRAM_DEPTH
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   input  wire logic                       load,
   input  wire logic                       step,
   input  wire logic                       is_wt,
   input  wire logic [LOG2_BRAM_NUM-1:0]   dat_buf_num,
   input  wire logic [LOG2BUF_DEP-1:0]     start_addr,
   output logic      [LOG2BUF_DEP:0]       cnt,
   output logic      [LOG2_BRAM_NUM-1:0]   bank,
   output logic      [LOG2_BRAM_DEPTH-1:0] bank_addr,
   output logic                            in_bound
);
   // One extra bit so that "one past the last bank" is representable.
   localparam int ABS_W = LOG2BUF_DEP + 1;
   localparam logic [ABS_W-1:0] WT_LIMIT = ABS_W'(BRAM_NUM) << LOG2_BRAM_DEPTH;

   logic [ABS_W-1:0]       base_q,  base_d;
   logic [ABS_W-1:0]       limit_q, limit_d;
   logic [LOG2BUF_DEP-1:0] addr_q,  addr_d;
   logic [ABS_W-1:0]       cnt_q,   cnt_d;
   logic [ABS_W-1:0]       region_edge;
   logic [ABS_W-1:0]       abs_addr;

   // Feature/weight split point in flat beat units.
   assign region_edge = {1'b0, dat_buf_num, {LOG2_BRAM_DEPTH{1'b0}}};

   always_comb begin
      base_d  = base_q;
      limit_d = limit_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      if (load) begin
         base_d  = is_wt ? region_edge : '0;
         limit_d = is_wt ? WT_LIMIT : region_edge;
         addr_d  = start_addr;
         cnt_d   = '0;
      end else if (step) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q  <= '0;
         limit_q <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         base_q  <= base_d;
         limit_q <= limit_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Sum wraps at ABS_W bits; anything at or above the limit is rejected.
   assign abs_addr  = base_q + {1'b0, addr_q} + cnt_q;
   assign bank      = abs_addr[LOG2BUF_DEP-1:LOG2_BRAM_DEPTH];
   assign bank_addr = abs_addr[LOG2_BRAM_DEPTH-1:0];
   assign in_bound  = abs_addr < limit_q;
   assign cnt       = cnt_q;

endmodule : wbuf_addr_gen
`default_nettype wire

// File: rtl/write_buf.sv
`default_nettype none
// ============================================================================
// Module   : write_buf
// Purpose  : Write-side controller of the banked conv on-chip buffer. Accepts
//            a feature/weight transfer command, then writes each DMA beat to
//            the proper logic-memory bank through a registered one-hot write
//            port. Feature region = banks [0, dat_buf_num), weight region =
//            banks [dat_buf_num, BRAM_NUM).
// Ports    : clk, rst_n (async, active-low)
//            bus (write_buf_if.slave) - command, data stream, write port,
//                                       done pulse, sticky err
// Revision : 1.0 - initial release
// ============================================================================
module write_buf
   import write_buf_pkg::*;
#(
   parameter int BRAM_NUM        = BRAM_NUM_DEF,
   parameter int LOG2_BRAM_NUM   = LOG2_BRAM_NUM_DEF,
   parameter int LOG2_BRAM_DEPTH = LOG2_BRAM_DEPTH_DEF,
   parameter int BASE_TIN        = BASE_TIN_DEF,
   parameter int MAX_DW          = MAX_DW_DEF
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   write_buf_if.slave bus
);
   localparam int LOG2BUF_DEP = LOG2_BRAM_NUM + LOG2_BRAM_DEPTH;
   localparam int BEAT_W      = BASE_TIN * MAX_DW;
   localparam int WA_W        = BRAM_NUM * LOG2_BRAM_DEPTH;

   wbuf_state_e                state_q;
   logic                       done_q;
   logic                       err_q;
   logic [LOG2BUF_DEP:0]       len_q,    len_d;
   logic [BRAM_NUM-1:0]        wr_en_q,  wr_en_d;
   logic [WA_W-1:0]            wr_addr_q, wr_addr_d;
   logic [BEAT_W-1:0]          wr_dat_q, wr_dat_d;

   logic                       cmd_rdy;
   logic                       in_rdy;
   logic                       cmd_accept;
   logic                       beat;
   logic                       last_beat;
   logic                       wr_fire;
   logic [LOG2BUF_DEP:0]       cnt;
   logic [LOG2_BRAM_NUM-1:0]   bank;
   logic [LOG2_BRAM_DEPTH-1:0] bank_addr;
   logic                       in_bound;

   assign cmd_rdy    = (state_q == ST_IDLE);
   assign in_rdy     = (state_q == ST_RUN) && (cnt != len_q);
   assign cmd_accept = bus.cmd_vld && cmd_rdy;
   assign beat       = bus.in_vld && in_rdy;
   assign last_beat  = beat && ((cnt + 1'b1) == len_q);
   // Out-of-region beats are consumed but never reach the memories.
   assign wr_fire    = beat && in_bound;

   wbuf_addr_gen #(
      .BRAM_NUM        (BRAM_NUM),
      .LOG2_BRAM_NUM   (LOG2_BRAM_NUM),
      .LOG2_BRAM_DEPTH (LOG2_BRAM_DEPTH)
   ) u_addr_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (cmd_accept),
      .step        (beat),
      .is_wt       (bus.cmd_is_wt),
      .dat_buf_num (bus.dat_buf_num),
      .start_addr  (bus.cmd_addr),
      .cnt         (cnt),
      .bank        (bank),
      .bank_addr   (bank_addr),
      .in_bound    (in_bound)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_accept) begin
                  err_q <= 1'b0;
                  if (bus.cmd_len == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (beat && !in_bound) begin
                  err_q <= 1'b1;
               end
               if (last_beat) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Per-bank decode: only the selected bank sees a non-zero address.
   for (genvar i = 0; i < BRAM_NUM; i++) begin : g_bank
      logic sel;
      assign sel          = wr_fire && (bank == LOG2_BRAM_NUM'(i));
      assign wr_en_d[i]   = sel;
      assign wr_addr_d[i*LOG2_BRAM_DEPTH +: LOG2_BRAM_DEPTH] = sel ? bank_addr : '0;
   end

   always_comb begin
      len_d    = len_q;
      wr_dat_d = wr_dat_q;
      if (cmd_accept) begin
         len_d = bus.cmd_len;
      end
      if (wr_fire) begin
         wr_dat_d = bus.in_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q     <= '0;
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         wr_dat_q  <= '0;
      end else begin
         len_q     <= len_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_dat_q  <= wr_dat_d;
      end
   end

   assign bus.cmd_rdy           = cmd_rdy;
   assign bus.in_rdy            = in_rdy;
   assign bus.logic_mem_wr_en   = wr_en_q;
   assign bus.logic_mem_wr_addr = wr_addr_q;
   assign bus.logic_mem_wr_dat  = wr_dat_q;
   assign bus.done              = done_q;
   assign bus.err               = err_q;

endmodule : write_buf
`default_nettype wire

// File: tb/tb_write_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_buf
// Purpose  : Directed self-checking bench for write_buf: bank crossing,
//            weight offset, out-of-region drops, stalls, zero-length command
//            and reset during a transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_buf;
   import write_buf_pkg::*;

   localparam int BN  = 16;
   localparam int LBN = 4;
   localparam int LD  = 10;
   localparam int TIN = 8;
   localparam int DW  = 16;
   localparam int DEP = LBN + LD;
   localparam int LW  = DEP + 1;
   localparam int BW  = TIN * DW;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   write_buf_if #(
      .BRAM_NUM(BN), .LOG2_BRAM_NUM(LBN), .LOG2_BRAM_DEPTH(LD),
      .BASE_TIN(TIN), .MAX_DW(DW)
   ) bus ();

   write_buf #(
      .BRAM_NUM(BN), .LOG2_BRAM_NUM(LBN), .LOG2_BRAM_DEPTH(LD),
      .BASE_TIN(TIN), .MAX_DW(DW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample and drive 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BW-1:0] beat_dat(input int k);
      return {4{32'hC0DE_0000 | 32'(k)}};
   endfunction

   task automatic expect_wr(input string tag, input int bank, input int addr,
                            input logic [BW-1:0] dat);
      logic [BN-1:0]    en;
      logic [BN*LD-1:0] ad;
      en = '0;
      en[bank] = 1'b1;
      ad = '0;
      ad[bank*LD +: LD] = LD'(addr);
      chk({tag, "_en"},   256'(bus.logic_mem_wr_en),   256'(en));
      chk({tag, "_addr"}, 256'(bus.logic_mem_wr_addr), 256'(ad));
      chk({tag, "_dat"},  256'(bus.logic_mem_wr_dat),  256'(dat));
   endtask

   task automatic send_cmd(input logic wt, input int addr, input int len);
      bus.cmd_vld   = 1'b1;
      bus.cmd_is_wt = wt;
      bus.cmd_addr  = DEP'(addr);
      bus.cmd_len   = LW'(len);
      chk("cmd_rdy_pre_accept", 256'(bus.cmd_rdy), 256'(1));
      tick();
      bus.cmd_vld = 1'b0;
   endtask

   initial begin
      int s1_bank [4] = '{0, 0, 1, 1};
      int s1_addr [4] = '{1022, 1023, 0, 1};
      logic s5_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int n;

      rst_n           = 1'b0;
      bus.dat_buf_num = '0;
      bus.cmd_vld     = 1'b0;
      bus.cmd_is_wt   = 1'b0;
      bus.cmd_addr    = '0;
      bus.cmd_len     = '0;
      bus.in_vld      = 1'b0;
      bus.in_dat      = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_wr_en",   256'(bus.logic_mem_wr_en),   256'(0));
      chk("rst_wr_addr", 256'(bus.logic_mem_wr_addr), 256'(0));
      chk("rst_wr_dat",  256'(bus.logic_mem_wr_dat),  256'(0));
      chk("rst_done",    256'(bus.done),    256'(0));
      chk("rst_err",     256'(bus.err),     256'(0));
      chk("rst_cmd_rdy", 256'(bus.cmd_rdy), 256'(1));
      chk("rst_in_rdy",  256'(bus.in_rdy),  256'(0));
      rst_n = 1'b1;
      tick();

      // Feature region, crossing from bank 0 into bank 1
      bus.dat_buf_num = LBN'(4);
      send_cmd(1'b0, 1022, 4);
      chk("s1_in_rdy",  256'(bus.in_rdy),  256'(1));
      chk("s1_cmd_rdy", 256'(bus.cmd_rdy), 256'(0));
      for (int k = 0; k < 4; k++) begin
         bus.in_vld = 1'b1;
         bus.in_dat = beat_dat(k);
         tick();
         expect_wr($sformatf("s1_b%0d", k), s1_bank[k], s1_addr[k], beat_dat(k));
         chk($sformatf("s1_done_b%0d", k), 256'(bus.done), 256'(k == 3));
      end
      bus.in_vld = 1'b0;
      chk("s1_in_rdy_done", 256'(bus.in_rdy), 256'(0));
      tick();
      chk("s1_done_clear", 256'(bus.done),            256'(0));
      chk("s1_wr_idle",    256'(bus.logic_mem_wr_en), 256'(0));
      chk("s1_cmd_rdy",    256'(bus.cmd_rdy),         256'(1));
      chk("s1_err",        256'(bus.err),             256'(0));

      // Weight region with offset: first weight bank is 4
      send_cmd(1'b1, 5, 1);
      bus.in_vld = 1'b1;
      bus.in_dat = beat_dat(20);
      tick();
      expect_wr("s2", 4, 5, beat_dat(20));
      chk("s2_done", 256'(bus.done), 256'(1));
      bus.in_vld = 1'b0;
      tick();
      chk("s2_done_clear", 256'(bus.done),            256'(0));
      chk("s2_wr_idle",    256'(bus.logic_mem_wr_en), 256'(0));

      // Feature region overrun: second beat lands at 1024 and is dropped
      bus.dat_buf_num = LBN'(1);
      send_cmd(1'b0, 1023, 2);
      bus.in_vld = 1'b1;
      bus.in_dat = beat_dat(30);
      tick();
      expect_wr("s3_b0", 0, 1023, beat_dat(30));
      chk("s3_err_b0", 256'(bus.err), 256'(0));
      bus.in_dat = beat_dat(31);
      tick();
      chk("s3_wr_en_b1", 256'(bus.logic_mem_wr_en), 256'(0));
      chk("s3_dat_hold", 256'(bus.logic_mem_wr_dat), 256'(beat_dat(30)));
      chk("s3_err_b1",   256'(bus.err),  256'(1));
      chk("s3_done",     256'(bus.done), 256'(1));
      bus.in_vld = 1'b0;
      repeat (3) tick();
      chk("s3_err_sticky", 256'(bus.err), 256'(1));

      // Weight overflow past the last bank; dat_buf_num changed mid-command
      bus.dat_buf_num = LBN'(15);
      send_cmd(1'b1, 1023, 2);
      chk("s4_err_cleared", 256'(bus.err), 256'(0));
      bus.dat_buf_num = LBN'(0);
      bus.in_vld = 1'b1;
      bus.in_dat = beat_dat(40);
      tick();
      expect_wr("s4_b0", 15, 1023, beat_dat(40));
      bus.in_dat = beat_dat(41);
      tick();
      chk("s4_wr_en_b1", 256'(bus.logic_mem_wr_en), 256'(0));
      chk("s4_err",      256'(bus.err),  256'(1));
      chk("s4_done",     256'(bus.done), 256'(1));
      bus.in_vld = 1'b0;
      tick();

      // Stalled stream: in_vld 1,0,0,1,1 with three beats
      bus.dat_buf_num = LBN'(4);
      send_cmd(1'b0, 10, 3);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         bus.in_vld = s5_pat[i];
         bus.in_dat = beat_dat(50 + i);
         tick();
         if (s5_pat[i]) begin
            expect_wr($sformatf("s5_c%0d", i), 0, 10 + n, beat_dat(50 + i));
            n++;
         end else begin
            chk($sformatf("s5_gap_c%0d", i), 256'(bus.logic_mem_wr_en), 256'(0));
         end
         chk($sformatf("s5_done_c%0d", i), 256'(bus.done), 256'(i == 4));
      end
      bus.in_vld = 1'b0;
      tick();

      // Zero-length command: done next cycle, no writes
      send_cmd(1'b0, 0, 0);
      chk("s5z_done",    256'(bus.done),            256'(1));
      chk("s5z_wr_en",   256'(bus.logic_mem_wr_en), 256'(0));
      chk("s5z_cmd_rdy", 256'(bus.cmd_rdy),         256'(0));
      chk("s5z_in_rdy",  256'(bus.in_rdy),          256'(0));
      tick();
      chk("s5z_done_clear", 256'(bus.done),            256'(0));
      chk("s5z_wr_en2",     256'(bus.logic_mem_wr_en), 256'(0));
      chk("s5z_cmd_rdy2",   256'(bus.cmd_rdy),         256'(1));

      // Reset in the middle of an 8-beat transfer
      send_cmd(1'b0, 100, 8);
      for (int k = 0; k < 3; k++) begin
         bus.in_vld = 1'b1;
         bus.in_dat = beat_dat(60 + k);
         tick();
         expect_wr($sformatf("s6_b%0d", k), 0, 100 + k, beat_dat(60 + k));
      end
      rst_n = 1'b0;
      #1;
      chk("s6_rst_wr_en",   256'(bus.logic_mem_wr_en), 256'(0));
      chk("s6_rst_done",    256'(bus.done),    256'(0));
      chk("s6_rst_cmd_rdy", 256'(bus.cmd_rdy), 256'(1));
      chk("s6_rst_in_rdy",  256'(bus.in_rdy),  256'(0));
      for (int k = 0; k < 2; k++) begin
         tick();
         chk($sformatf("s6_rst_hold_done%0d", k), 256'(bus.done), 256'(0));
      end
      bus.in_vld = 1'b0;
      rst_n = 1'b1;
      tick();
      send_cmd(1'b1, 0, 2);
      for (int k = 0; k < 2; k++) begin
         bus.in_vld = 1'b1;
         bus.in_dat = beat_dat(70 + k);
         tick();
         expect_wr($sformatf("s6_new_b%0d", k), 4, k, beat_dat(70 + k));
         chk($sformatf("s6_new_done_b%0d", k), 256'(bus.done), 256'(k == 1));
      end
      bus.in_vld = 1'b0;
      tick();
      chk("s6_new_cmd_rdy", 256'(bus.cmd_rdy), 256'(1));
      chk("s6_new_err",     256'(bus.err),     256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_write_buf
`default_nettype wire
